// File: rtl/fu_alu_pipe.sv
// Pipelined RV32I/RV64I integer ALU functional unit. It has valid/ready backpressure
// toward the CDB and flushes entries younger than a mispredicted branch by ROB age.
module fu_alu_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ROB_W  = 5,
    parameter int unsigned PREG_W = 7,
    parameter int unsigned STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROB_W-1:0]  curr_rob_tag,
    input  logic              mispredict,
    input  logic [ROB_W-1:0]  mispredict_tag,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   ps1_data,
    input  logic [XLEN-1:0]   ps2_data,
    input  logic [PREG_W-1:0] pd,
    input  logic [ROB_W-1:0]  rob_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [PREG_W-1:0] out_pd,
    output logic [ROB_W-1:0]  out_rob,
    output logic              out_illegal,
    output logic [2:0]        occupancy
);
    localparam int unsigned SHW        = $clog2(XLEN);
    localparam logic [6:0]  OPC_OP_IMM = 7'h13;
    localparam logic [6:0]  OPC_OP     = 7'h33;
    localparam logic [6:0]  OPC_LUI    = 7'h37;
    localparam logic [6:0]  OPC_AUIPC  = 7'h17;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [PREG_W-1:0] pd;
        logic [ROB_W-1:0]  rob;
        logic              illegal;
    } entry_t;

    entry_t            st [STAGES];
    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_kill;
    logic [STAGES-1:0] valid_next;
    logic [2:0]        occ_next;
    logic              issue_kill;
    logic              accept;
    logic              advance;
    entry_t            issue_entry;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   res;
    logic [SHW-1:0]    shamt;
    logic [6:0]        f7;
    logic              illegal;
    logic              is_op;
    logic              base_ok;

    // Modular ROB age compare; equal age is not younger.
    function automatic logic is_younger(input logic [ROB_W-1:0] r, input logic [ROB_W-1:0] head,
                                        input logic [ROB_W-1:0] br);
        return ROB_W'(r - head) > ROB_W'(br - head);
    endfunction

    // Stage-0 decode and execute. On RV64, OP-IMM func7[0] is shamt bit 5.
    always_comb begin
        is_op   = (opcode == OPC_OP);
        opb     = is_op ? ps2_data : imm;
        shamt   = opb[SHW-1:0];
        f7      = (!is_op && XLEN == 64) ? {func7[6:1], 1'b0} : func7;
        base_ok = !is_op || (func7 == 7'h00);
        res     = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI:   res = imm;
            OPC_AUIPC: res = pc + imm;
            OPC_OP, OPC_OP_IMM: begin
                case (func3)
                    3'd0: begin
                        if (is_op && func7 == 7'h20) res = ps1_data - opb;
                        else if (base_ok)           res = ps1_data + opb;
                        else                        illegal = 1'b1;
                    end
                    3'd1: if (f7 == 7'h00) res = ps1_data << shamt; else illegal = 1'b1;
                    3'd2: if (base_ok) res = XLEN'($signed(ps1_data) < $signed(opb)); else illegal = 1'b1;
                    3'd3: if (base_ok) res = XLEN'(ps1_data < opb); else illegal = 1'b1;
                    3'd4: if (base_ok) res = ps1_data ^ opb; else illegal = 1'b1;
                    3'd5: begin
                        if (f7 == 7'h00)      res = ps1_data >> shamt;
                        else if (f7 == 7'h20) res = $signed(ps1_data) >>> shamt;
                        else                  illegal = 1'b1;
                    end
                    3'd6: if (base_ok) res = ps1_data | opb; else illegal = 1'b1;
                    default: if (base_ok) res = ps1_data & opb; else illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            st_kill[i] = mispredict && is_younger(st[i].rob, curr_rob_tag, mispredict_tag);
        end
    end

    assign issue_kill  = mispredict && is_younger(rob_index, curr_rob_tag, mispredict_tag);
    assign out_valid   = st_valid[STAGES-1] && !st_kill[STAGES-1];
    assign advance     = !out_valid || out_ready;
    assign issue_ready = advance;
    assign accept      = issue_valid && advance && !issue_kill;
    assign issue_entry = '{data: res, pd: pd, rob: rob_index, illegal: illegal};

    // Post-flush valids: shift on advance, otherwise hold in place.
    always_comb begin
        valid_next = st_valid & ~st_kill;
        if (advance) begin
            valid_next[0] = accept;
            for (int i = 1; i < STAGES; i++) begin
                valid_next[i] = st_valid[i-1] && !st_kill[i-1];
            end
        end
        occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_next = occ_next + 3'(valid_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_valid  <= '0;
            occupancy <= '0;
            for (int i = 0; i < STAGES; i++) begin
                st[i] <= '0;
            end
        end else begin
            st_valid  <= valid_next;
            occupancy <= occ_next;
            if (advance) begin
                st[0] <= issue_entry;
                for (int i = 1; i < STAGES; i++) begin
                    st[i] <= st[i-1];
                end
            end
        end
    end

    assign out_data    = st[STAGES-1].data;
    assign out_pd      = st[STAGES-1].pd;
    assign out_rob     = st[STAGES-1].rob;
    assign out_illegal = st[STAGES-1].illegal;

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Self-checking bench for fu_alu_pipe: directed scenarios plus randomized traffic
// against an in-order scoreboard model with flush and stall.
module tb_fu_alu_pipe;
    localparam int XLEN = 32, ROB_W = 5, PREG_W = 7, STAGES = 2;

    logic              clk, reset;
    logic [ROB_W-1:0]  curr_rob_tag, mispredict_tag, rob_index, out_rob;
    logic              mispredict, issue_valid, issue_ready, out_valid, out_ready, out_illegal;
    logic [6:0]        opcode, func7;
    logic [2:0]        func3, occupancy;
    logic [XLEN-1:0]   imm, pc, ps1_data, ps2_data, out_data;
    logic [PREG_W-1:0] pd, out_pd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [6:0]  pd;
        logic [4:0]  rob;
        logic        ill;
    } exp_t;

    exp_t q[$];

    fu_alu_pipe #(.XLEN(XLEN), .ROB_W(ROB_W), .PREG_W(PREG_W), .STAGES(STAGES)) dut (
        .clk(clk), .reset(reset), .curr_rob_tag(curr_rob_tag), .mispredict(mispredict),
        .mispredict_tag(mispredict_tag), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .func3(func3), .func7(func7), .imm(imm), .pc(pc),
        .ps1_data(ps1_data), .ps2_data(ps2_data), .pd(pd), .rob_index(rob_index),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pd(out_pd),
        .out_rob(out_rob), .out_illegal(out_illegal), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference ALU, derived from the RV32I mnemonics.
    function automatic exp_t ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] im, input logic [31:0] pcv,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [6:0] d, input logic [4:0] r);
        exp_t e;
        logic [31:0] s2;
        int sh;
        bit legal;
        e.pd = d; e.rob = r; e.ill = 1'b0; e.data = 32'd0;
        s2 = (opc == 7'h33) ? b : im;
        sh = int'(s2 % 32);
        if (opc == 7'h37) e.data = im;
        else if (opc == 7'h17) e.data = pcv + im;
        else if (opc == 7'h13 || opc == 7'h33) begin
            if (opc == 7'h13) legal = (f3 != 3'd1 && f3 != 3'd5) || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
            else              legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (!legal) e.ill = 1'b1;
            else begin
                case (f3)
                    3'd0: e.data = (opc == 7'h33 && f7 == 7'h20) ? a - s2 : a + s2;
                    3'd1: e.data = a << sh;
                    3'd2: e.data = (int'(a) < int'(s2)) ? 32'd1 : 32'd0;
                    3'd3: e.data = (a < s2) ? 32'd1 : 32'd0;
                    3'd4: e.data = a ^ s2;
                    3'd5: begin
                        e.data = a >> sh;
                        if (f7 == 7'h20 && a[31]) e.data = e.data | ~(32'hFFFF_FFFF >> sh);
                    end
                    3'd6: e.data = a | s2;
                    default: e.data = a & s2;
                endcase
            end
        end else e.ill = 1'b1;
        return e;
    endfunction

    function automatic bit m_younger(input int r, input int head, input int br);
        return ((r - head + 32) % 32) > ((br - head + 32) % 32);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_issue();
        issue_valid = 1'b0;
        mispredict  = 1'b0;
    endtask

    task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] im, input logic [31:0] pcv, input logic [31:0] a,
                          input logic [31:0] b, input logic [6:0] d, input logic [4:0] r);
        issue_valid = 1'b1; opcode = opc; func3 = f3; func7 = f7; imm = im; pc = pcv;
        ps1_data = a; ps2_data = b; pd = d; rob_index = r;
    endtask

    task automatic do_reset();
        reset = 1'b0; clear_issue(); out_ready = 1'b1; curr_rob_tag = '0; mispredict_tag = '0;
        set_op(7'h13, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 7'd0, 5'd0);
        issue_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; clear_issue(); out_ready = 1'b1;
        #3;
        checks++; if ({out_valid, out_illegal, occupancy} !== 5'd0) begin errors++; $display("FAIL reset_ctl: got %b want 00000", {out_valid, out_illegal, occupancy}); end
        checks++; if ({out_data, out_pd, out_rob} !== '0) begin errors++; $display("FAIL reset_fields: got %h/%h/%h want 0", out_data, out_pd, out_rob); end
        do_reset();
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
    endtask

    task automatic test_addi_latency();
        do_reset();
        set_op(7'h13, 3'd0, 7'd0, 32'hFFFF_FFFD, 32'd0, 32'd5, 32'd0, 7'd9, 5'd4);
        #1;
        checks++; if ({issue_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL addi_c0: got %b want 10", {issue_ready, out_valid}); end
        next_cycle(); clear_issue(); #1;
        checks++; if ({out_valid, occupancy} !== 4'b0001) begin errors++; $display("FAIL addi_c1: got %b want 0001", {out_valid, occupancy}); end
        next_cycle(); #1;
        checks++; if ({out_valid, out_data, out_rob, out_pd, occupancy} !== {1'b1, 32'd2, 5'd4, 7'd9, 3'd1}) begin
            errors++; $display("FAIL addi_c2: got v=%b d=%h rob=%0d pd=%0d occ=%0d want 1/2/4/9/1", out_valid, out_data, out_rob, out_pd, occupancy); end
        next_cycle(); #1;
        checks++; if ({out_valid, occupancy} !== 4'b0000) begin errors++; $display("FAIL addi_c3: got %b want 0000", {out_valid, occupancy}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [3];
        want[0] = 32'd7; want[1] = 32'hF800_0000; want[2] = 32'd1;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: set_op(7'h33, 3'd0, 7'h20, 32'd0, 32'd0, 32'd10, 32'd3, 7'd1, 5'd1);
                1: set_op(7'h33, 3'd5, 7'h20, 32'd0, 32'd0, 32'h8000_0000, 32'd4, 7'd2, 5'd2);
                2: set_op(7'h13, 3'd3, 7'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 7'd3, 5'd3);
                default: clear_issue();
            endcase
            #1;
            if (c >= 2) begin
                checks++; if ({out_valid, out_data} !== {1'b1, want[c-2]}) begin
                    errors++; $display("FAIL b2b_%0d: got v=%b d=%h want 1/%h", c - 2, out_valid, out_data, want[c-2]); end
            end
            next_cycle();
        end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        set_op(7'h33, 3'd0, 7'd0, 32'd0, 32'd0, 32'd1, 32'd2, 7'd11, 5'd1);
        next_cycle();
        set_op(7'h13, 3'd4, 7'd0, 32'hFF, 32'd0, 32'hF0, 32'd0, 7'd12, 5'd2);
        next_cycle();
        set_op(7'h37, 3'd0, 7'd0, 32'hDEAD_0000, 32'd0, 32'd0, 32'd0, 7'd13, 5'd3);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({out_valid, issue_ready, out_data, out_pd, occupancy} !== {2'b10, 32'd3, 7'd11, 3'd2}) begin
                errors++; $display("FAIL stall_hold_%0d: got v=%b rdy=%b d=%h pd=%0d occ=%0d want 1/0/3/11/2", c, out_valid, issue_ready, out_data, out_pd, occupancy); end
            next_cycle();
        end
        out_ready = 1'b1; clear_issue(); #1;
        checks++; if ({out_valid, out_data} !== {1'b1, 32'd3}) begin errors++; $display("FAIL stall_out0: got %b/%h want 1/3", out_valid, out_data); end
        next_cycle(); #1;
        checks++; if ({out_valid, out_data, out_pd} !== {1'b1, 32'h0F, 7'd12}) begin errors++; $display("FAIL stall_out1: got %b/%h/%0d want 1/f/12", out_valid, out_data, out_pd); end
        next_cycle(); #1;
        checks++; if ({out_valid, occupancy} !== 4'd0) begin errors++; $display("FAIL stall_tail: got %b want 0000", {out_valid, occupancy}); end
    endtask

    task automatic test_flush_wrap();
        do_reset();
        curr_rob_tag = 5'd30;
        set_op(7'h13, 3'd0, 7'd0, 32'd31, 32'd0, 32'd100, 32'd0, 7'd1, 5'd31);
        next_cycle();
        set_op(7'h13, 3'd0, 7'd0, 32'd0, 32'd0, 32'd100, 32'd0, 7'd2, 5'd0);
        next_cycle();
        set_op(7'h13, 3'd0, 7'd0, 32'd2, 32'd0, 32'd100, 32'd0, 7'd3, 5'd2);
        #1;
        checks++; if ({out_valid, out_rob, out_data} !== {1'b1, 5'd31, 32'd131}) begin errors++; $display("FAIL flush_r31: got %b/%0d/%0d want 1/31/131", out_valid, out_rob, out_data); end
        next_cycle();
        set_op(7'h13, 3'd0, 7'd0, 32'd30, 32'd0, 32'd100, 32'd0, 7'd4, 5'd30);
        mispredict = 1'b1; mispredict_tag = 5'd0;
        #1;
        checks++; if ({out_valid, out_rob, occupancy} !== {1'b1, 5'd0, 3'd2}) begin errors++; $display("FAIL flush_r0: got %b/%0d/occ %0d want 1/0/2", out_valid, out_rob, occupancy); end
        next_cycle(); clear_issue(); #1;
        checks++; if ({out_valid, occupancy} !== 4'b0001) begin errors++; $display("FAIL flush_drop: got %b want 0001", {out_valid, occupancy}); end
        next_cycle(); #1;
        checks++; if ({out_valid, out_rob} !== {1'b1, 5'd30}) begin errors++; $display("FAIL flush_older: got %b/%0d want 1/30", out_valid, out_rob); end
        next_cycle(); #1;
        checks++; if ({out_valid, occupancy} !== 4'd0) begin errors++; $display("FAIL flush_tail: got %b want 0000", {out_valid, occupancy}); end
        curr_rob_tag = '0;
    endtask

    task automatic test_illegal_auipc();
        do_reset();
        set_op(7'h7F, 3'd0, 7'd0, 32'h55, 32'd0, 32'h1234, 32'h5678, 7'd5, 5'd5);
        next_cycle();
        set_op(7'h17, 3'd0, 7'd0, 32'h2000, 32'h1000, 32'd0, 32'd0, 7'd6, 5'd6);
        next_cycle(); clear_issue(); #1;
        checks++; if ({out_valid, out_illegal, out_data} !== {2'b11, 32'd0}) begin errors++; $display("FAIL illegal: got %b/%b/%h want 1/1/0", out_valid, out_illegal, out_data); end
        next_cycle(); #1;
        checks++; if ({out_valid, out_illegal, out_data} !== {2'b10, 32'h3000}) begin errors++; $display("FAIL auipc: got %b/%b/%h want 1/0/3000", out_valid, out_illegal, out_data); end
        next_cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_op(7'h13, 3'd0, 7'd0, 32'd1, 32'd0, 32'd1, 32'd0, 7'd7, 5'd1);
        next_cycle();
        set_op(7'h13, 3'd0, 7'd0, 32'd2, 32'd0, 32'd2, 32'd0, 7'd8, 5'd2);
        next_cycle();
        clear_issue(); out_ready = 1'b0; #1;
        checks++; if ({out_valid, occupancy} !== 4'b1010) begin errors++; $display("FAIL areset_pre: got %b want 1010", {out_valid, occupancy}); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({out_valid, out_illegal, occupancy, out_data, out_pd, out_rob} !== '0) begin
            errors++; $display("FAIL areset_now: got v=%b occ=%0d d=%h pd=%0d rob=%0d want all 0", out_valid, occupancy, out_data, out_pd, out_rob); end
        next_cycle(); next_cycle();
        reset = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_after_%0d: got %b want 0", c, out_valid); end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic [6:0] opc, f7;
        exp_t e;
        do_reset();
        q.delete();
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: opc = 7'h13;
                4, 5, 6:    opc = 7'h33;
                7:          opc = 7'h37;
                8:          opc = 7'h17;
                default:    opc = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            set_op(opc, 3'($urandom), f7, $urandom, $urandom, $urandom, $urandom, 7'($urandom), 5'($urandom));
            issue_valid    = ($urandom_range(0, 9) < 7);
            out_ready      = ($urandom_range(0, 3) != 0);
            mispredict     = ($urandom_range(0, 7) == 0);
            mispredict_tag = 5'($urandom);
            curr_rob_tag   = 5'($urandom);
            #1;
            checks++; if (occupancy !== 3'(q.size())) begin errors++; $display("FAIL rnd_occ c%0d: got %0d want %0d", c, occupancy, q.size()); end
            if (mispredict) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (m_younger(int'(q[i].rob), int'(curr_rob_tag), int'(mispredict_tag))) q.delete(i);
                end
            end
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rnd_spurious c%0d: got out_valid=1 want no pending result", c); end
                else begin
                    e = q[0];
                    if ({out_data, out_pd, out_rob, out_illegal} !== {e.data, e.pd, e.rob, e.ill}) begin
                        errors++; $display("FAIL rnd_result c%0d: got %h/%0d/%0d/%b want %h/%0d/%0d/%b", c, out_data, out_pd, out_rob, out_illegal, e.data, e.pd, e.rob, e.ill); end
                    if (out_ready) void'(q.pop_front());
                end
            end
            checks++; if (issue_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, issue_ready, !out_valid || out_ready); end
            if (issue_valid && issue_ready && !(mispredict && m_younger(int'(rob_index), int'(curr_rob_tag), int'(mispredict_tag))))
                q.push_back(ref_op(opcode, func3, func7, imm, pc, ps1_data, ps2_data, pd, rob_index));
            next_cycle();
        end
        clear_issue(); out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                e = q.pop_front();
                checks++; if ({out_data, out_pd, out_rob, out_illegal} !== {e.data, e.pd, e.rob, e.ill}) begin
                    errors++; $display("FAIL rnd_drain: got %h/%0d/%0d/%b want %h/%0d/%0d/%b", out_data, out_pd, out_rob, out_illegal, e.data, e.pd, e.rob, e.ill); end
            end
            next_cycle();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_lost: got %0d results never delivered want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_addi_latency();
        test_back_to_back();
        test_stall();
        test_flush_wrap();
        test_illegal_auipc();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
